// File: rtl/mem_sorter.sv
// In-place ascending bubble sorter that owns a single-read/single-write memory.
// Optional early exit on a swap-free pass: define MEM_SORTER_EARLY_EXIT_EN.
package mem_sorter_pkg;
  localparam int NUM_ROWS = 16;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = $clog2(NUM_ROWS);
  typedef logic [ADDR_W-1:0] t_addr;
  typedef logic [DATA_W-1:0] t_data;
endpackage

module mem_sorter
  import mem_sorter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output t_addr      rd_addr,
  input  t_data      rd_data,
  output logic       wr_en,
  output t_addr      wr_addr,
  output t_data      wr_data,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CMP   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;
  t_data  carry_q, carry_d;
  t_addr  idx_q, idx_d;
  t_addr  limit_q, limit_d;
  logic   dirty_q, dirty_d;
  logic   swapped_q, swapped_d;
  t_addr  wr_addr_q;
  t_data  wr_data_q;
  t_addr  idx_inc;

  assign idx_inc   = t_addr'(idx_q + 1'b1);
  assign busy      = (state_q == S_LOAD) || (state_q == S_CMP) || (state_q == S_FLUSH);
  assign done      = (state_q == S_DONE);
  assign dbg_state = state_q;

  // Start handshake: start is a request sampled only in IDLE/DONE; busy/done are
  // pure state decodes, so they change exactly at the edge that changes state.
  always_comb begin
    state_d   = state_q;
    carry_d   = carry_q;
    idx_d     = idx_q;
    limit_d   = limit_q;
    dirty_d   = dirty_q;
    swapped_d = swapped_q;
    rd_addr   = '0;
    wr_en     = 1'b0;
    wr_addr   = wr_addr_q;
    wr_data   = wr_data_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          limit_d = t_addr'(NUM_ROWS - 1);
        end
      end
      S_LOAD: begin
        carry_d   = rd_data;
        idx_d     = '0;
        dirty_d   = 1'b0;
        swapped_d = 1'b0;
        state_d   = S_CMP;
      end
      S_CMP: begin
        rd_addr = idx_inc;
        // carry holds the running maximum; dirty means its home slot is stale.
        if (carry_q > rd_data) begin
          wr_en     = 1'b1;
          wr_addr   = idx_q;
          wr_data   = rd_data;
          dirty_d   = 1'b1;
          swapped_d = 1'b1;
        end else begin
          if (dirty_q) begin
            wr_en   = 1'b1;
            wr_addr = idx_q;
            wr_data = carry_q;
          end
          carry_d = rd_data;
          dirty_d = 1'b0;
        end
        idx_d = idx_inc;
        if (idx_inc == limit_q) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        rd_addr = idx_q;
        if (dirty_q) begin
          wr_en   = 1'b1;
          wr_addr = limit_q;
          wr_data = carry_q;
        end
        dirty_d = 1'b0;
        limit_d = t_addr'(limit_q - 1'b1);
        if (limit_q == t_addr'(1)) begin
          state_d = S_DONE;
        end else begin
`ifdef MEM_SORTER_EARLY_EXIT_EN
          state_d = swapped_q ? S_LOAD : S_DONE;
`else
          state_d = S_LOAD;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      carry_q   <= '0;
      idx_q     <= '0;
      limit_q   <= '0;
      dirty_q   <= 1'b0;
      swapped_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      carry_q   <= carry_d;
      idx_q     <= idx_d;
      limit_q   <= limit_d;
      dirty_q   <= dirty_d;
      swapped_q <= swapped_d;
      wr_addr_q <= wr_addr;
      wr_data_q <= wr_data;
    end
  end

endmodule

// File: tb/tb_mem_sorter.sv
// Directed bench for mem_sorter with a behavioural memory and an energy-rule monitor.
module tb_mem_sorter;
  import mem_sorter_pkg::*;

`ifdef MEM_SORTER_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif
  localparam int FULL_CYC = 150;

  logic       clk = 1'b0;
  logic       rst_n, start;
  logic       busy, done, wr_en;
  t_addr      rd_addr, wr_addr;
  t_data      rd_data, wr_data;
  logic [2:0] dbg_state;

  t_data      mem [NUM_ROWS];
  logic       ld_en;
  t_addr      ld_addr;
  t_data      ld_data;
  t_data      pattern [NUM_ROWS];
  logic [DATA_W-1:0] exp_q[$];

  int checks = 0;
  int failures = 0;
  int wr_total = 0;
  int energy_err = 0;
  t_addr prev_wa = '0;
  t_data prev_wd = '0;

  always #5 clk = ~clk;

  mem_sorter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .dbg_state (dbg_state)
  );

  assign rd_data = mem[rd_addr];

  always @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    else if (ld_en) mem[ld_addr] <= ld_data;
  end

  // Counts writes and flags write-port toggles without wr_en, writes outside CMP/FLUSH,
  // and a non-zero read address while not busy.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) wr_total++;
      if (!wr_en && (wr_addr != prev_wa || wr_data != prev_wd)) energy_err++;
      if (wr_en && !(dbg_state == 3'd2 || dbg_state == 3'd3)) energy_err++;
      if (!busy && rd_addr != '0) energy_err++;
    end
    prev_wa = wr_addr;
    prev_wd = wr_data;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load_pattern();
    for (int i = 0; i < NUM_ROWS; i++) begin
      @(negedge clk);
      ld_en   = 1'b1;
      ld_addr = t_addr'(i);
      ld_data = pattern[i];
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic check_rows(input string tag);
    for (int i = 0; i < NUM_ROWS; i++) begin
      check_eq(tag, 32'(mem[i]), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic push_identity();
    for (int i = 0; i < NUM_ROWS; i++) exp_q.push_back(DATA_W'(i));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_done"}, 32'(done), 0);
    check_eq({tag, "_wr_en"}, 32'(wr_en), 0);
    check_eq({tag, "_wr_addr"}, 32'(wr_addr), 0);
    check_eq({tag, "_wr_data"}, 32'(wr_data), 0);
    check_eq({tag, "_rd_addr"}, 32'(rd_addr), 0);
    check_eq({tag, "_state"}, 32'(dbg_state), 0);
  endtask

  // Accept edge is t0; cycles counts edges after t0 until done is seen high.
  task automatic run_sort(input int pulse_at, input int abort_at,
                          output int cycles, output int busy_cyc, output int writes);
    int  w0;
    bit  finished;
    w0       = wr_total;
    cycles   = 0;
    busy_cyc = 0;
    finished = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq("accept_busy", 32'(busy), 1);
    check_eq("accept_done_clr", 32'(done), 0);
    if (busy) busy_cyc++;
    while (!finished && cycles < 400) begin
      @(posedge clk);
      #1;
      cycles++;
      start = 1'b0;
      if (cycles == pulse_at) start = 1'b1;
      if (done) finished = 1'b1;
      else if (busy) busy_cyc++;
      if (cycles == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        finished = 1'b1;
      end
    end
    start = 1'b0;
    if (!finished) check_eq("done_timeout", 32'(done), 1);
    writes = wr_total - w0;
  endtask

  initial begin
    int cyc, bcyc, wr;
    rst_n = 1'b0;
    start = 1'b0;
    ld_en = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Already sorted
    for (int i = 0; i < NUM_ROWS; i++) pattern[i] = DATA_W'(i);
    load_pattern();
    run_sort(0, 0, cyc, bcyc, wr);
    check_eq("sorted_cycles", cyc, EE ? 17 : FULL_CYC);
    check_eq("sorted_busy", bcyc, EE ? 17 : FULL_CYC);
    check_eq("sorted_writes", wr, 0);
    push_identity();
    check_rows("sorted_row");

    // Few local swaps
    pattern = '{8'd1, 8'd0, 8'd3, 8'd2, 8'd7, 8'd5, 8'd6, 8'd4,
                8'd8, 8'd9, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15};
    load_pattern();
    run_sort(0, 0, cyc, bcyc, wr);
    check_eq("mixed_cycles", cyc, EE ? 62 : FULL_CYC);
    check_eq("mixed_writes", wr, 12);
    push_identity();
    check_rows("mixed_row");

    // Reverse order, with a start pulse while busy that must be ignored
    for (int i = 0; i < NUM_ROWS; i++) pattern[i] = DATA_W'(NUM_ROWS - 1 - i);
    load_pattern();
    run_sort(5, 0, cyc, bcyc, wr);
    check_eq("reverse_cycles", cyc, FULL_CYC);
    check_eq("reverse_busy", bcyc, FULL_CYC);
    check_eq("reverse_writes", wr, 135);
    push_identity();
    check_rows("reverse_row");
    repeat (10) @(posedge clk);
    #1;
    check_eq("done_held", 32'(done), 1);
    check_eq("done_state", 32'(dbg_state), 4);
    check_eq("done_busy", 32'(busy), 0);
    run_sort(0, 0, cyc, bcyc, wr);
    check_eq("resort_cycles", cyc, EE ? 17 : FULL_CYC);
    check_eq("resort_writes", wr, 0);

    // Duplicates
    pattern = '{8'd3, 8'd3, 8'd1, 8'd1, 8'd5, 8'd5, 8'd0, 8'd0,
                8'd7, 8'd7, 8'd2, 8'd2, 8'd6, 8'd6, 8'd4, 8'd4};
    load_pattern();
    run_sort(0, 0, cyc, bcyc, wr);
    for (int i = 0; i < NUM_ROWS; i++) exp_q.push_back(DATA_W'(i / 2));
    check_rows("dup_row");

    // Reset in the middle of a sort, then a clean restart
    for (int i = 0; i < NUM_ROWS; i++) pattern[i] = DATA_W'(NUM_ROWS - 1 - i);
    load_pattern();
    run_sort(0, 20, cyc, bcyc, wr);
    check_eq("abort_cycle", cyc, 20);
    repeat (2) @(negedge clk);
    check_reset_outputs("abort_hold");
    rst_n = 1'b1;
    for (int i = 0; i < NUM_ROWS; i++) pattern[i] = DATA_W'(i);
    load_pattern();
    run_sort(0, 0, cyc, bcyc, wr);
    check_eq("restart_cycles", cyc, EE ? 17 : FULL_CYC);
    check_eq("restart_writes", wr, 0);
    push_identity();
    check_rows("restart_row");

    check_eq("energy_rules", energy_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
